// File: rtl/lsu.sv
// Load/store unit: initiator on the byte-addressed data-memory port, with a
// one-entry store buffer and a two-state load sequencer.
module lsu #(
    parameter int unsigned DM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        DMWr,
    output logic [31:0] addr,
    output logic [31:0] din,
    output logic [2:0]  dm_ctrl,
    input  logic [31:0] dout,
    output logic        busy
);

    localparam logic [2:0] CTRL_W  = 3'd0;
    localparam logic [2:0] CTRL_H  = 3'd1;
    localparam logic [2:0] CTRL_HU = 3'd2;
    localparam logic [2:0] CTRL_B  = 3'd3;
    localparam logic [2:0] CTRL_BU = 3'd4;
    localparam logic [31:0] DM_LIMIT = 32'(DM_BYTES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    function automatic logic [2:0] access_size(input logic [2:0] ctrl);
        case (ctrl)
            CTRL_W:          access_size = 3'd4;
            CTRL_H, CTRL_HU: access_size = 3'd2;
            default:         access_size = 3'd1;
        endcase
    endfunction

    function automatic logic code_legal(input logic we, input logic [2:0] ctrl);
        if (we) begin
            code_legal = (ctrl == CTRL_W) || (ctrl == CTRL_H) || (ctrl == CTRL_B);
        end else begin
            code_legal = (ctrl <= CTRL_BU);
        end
    endfunction

    function automatic logic ranges_overlap(input logic [31:0] a, input logic [2:0] a_sz,
                                            input logic [31:0] b, input logic [2:0] b_sz);
        logic [32:0] a_end;
        logic [32:0] b_end;
        a_end = {1'b0, a} + {30'd0, a_sz};
        b_end = {1'b0, b} + {30'd0, b_sz};
        ranges_overlap = ({1'b0, a} < b_end) && ({1'b0, b} < a_end);
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] ctrl, input logic [31:0] data);
        case (ctrl)
            CTRL_B:  load_extend = {{24{data[7]}}, data[7:0]};
            CTRL_BU: load_extend = {24'd0, data[7:0]};
            CTRL_H:  load_extend = {{16{data[15]}}, data[15:0]};
            CTRL_HU: load_extend = {16'd0, data[15:0]};
            default: load_extend = data;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;

    logic        sb_valid_r;
    logic [31:0] sb_addr_r;
    logic [31:0] sb_data_r;
    logic [2:0]  sb_ctrl_r;

    logic [31:0] ld_addr_r;
    logic [2:0]  ld_ctrl_r;
    logic [4:0]  ld_rd_r;
    logic        ld_err_r;

    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic [4:0]  rsp_rd_r;
    logic        rsp_err_r;

    logic        misalign_s;
    logic        req_err_s;
    logic        overlap_s;
    logic        ready_s;
    logic        ld_accept_s;
    logic        st_accept_s;

    logic        dm_we_s;
    logic [31:0] dm_addr_s;
    logic [31:0] dm_din_s;
    logic [2:0]  dm_ctrl_s;

    // Request decode: error classification, store-buffer hazard and handshake.
    always_comb begin
        misalign_s  = 1'b0;
        req_err_s   = 1'b0;
        overlap_s   = 1'b0;
        ready_s     = 1'b0;
        ld_accept_s = 1'b0;
        st_accept_s = 1'b0;
        case (req_ctrl)
            CTRL_W:          misalign_s = (req_addr[1:0] != 2'b00);
            CTRL_H, CTRL_HU: misalign_s = req_addr[0];
            default:         misalign_s = 1'b0;
        endcase
        req_err_s = !code_legal(req_we, req_ctrl) || misalign_s || (req_addr >= DM_LIMIT);
        overlap_s = sb_valid_r &&
                    ranges_overlap(sb_addr_r, access_size(sb_ctrl_r), req_addr, access_size(req_ctrl));
        // A load that would read bytes still sitting in the buffer waits for the drain.
        ready_s     = (state_r == ST_IDLE) && !(!req_we && overlap_s);
        ld_accept_s = req_valid && ready_s && !req_we;
        st_accept_s = req_valid && ready_s && req_we;
    end

    // Next-state logic for the load sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ld_accept_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Captured load request, replayed on the port during LOAD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_addr_r <= 32'd0;
            ld_ctrl_r <= 3'd0;
            ld_rd_r   <= 5'd0;
            ld_err_r  <= 1'b0;
        end else if (ld_accept_s) begin
            ld_addr_r <= req_addr;
            ld_ctrl_r <= req_ctrl;
            ld_rd_r   <= req_rd;
            ld_err_r  <= req_err_s;
        end else begin
            ld_addr_r <= ld_addr_r;
            ld_ctrl_r <= ld_ctrl_r;
            ld_rd_r   <= ld_rd_r;
            ld_err_r  <= ld_err_r;
        end
    end

    // Store buffer: a new store replaces the entry draining in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_valid_r <= 1'b0;
            sb_addr_r  <= 32'd0;
            sb_data_r  <= 32'd0;
            sb_ctrl_r  <= 3'd0;
        end else if (st_accept_s && !req_err_s) begin
            sb_valid_r <= 1'b1;
            sb_addr_r  <= req_addr;
            sb_data_r  <= req_wdata;
            sb_ctrl_r  <= req_ctrl;
        end else if ((state_r == ST_IDLE) && sb_valid_r) begin
            sb_valid_r <= 1'b0;
        end else begin
            sb_valid_r <= sb_valid_r;
        end
    end

    // Response register; load and store-error sources are mutually exclusive by construction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_rd_r    <= 5'd0;
            rsp_err_r   <= 1'b0;
        end else if (state_r == ST_LOAD) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= ld_err_r ? 32'd0 : load_extend(ld_ctrl_r, dout);
            rsp_rd_r    <= ld_rd_r;
            rsp_err_r   <= ld_err_r;
        end else if (st_accept_s && req_err_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= 32'd0;
            rsp_rd_r    <= req_rd;
            rsp_err_r   <= 1'b1;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_rd_r    <= 5'd0;
            rsp_err_r   <= 1'b0;
        end
    end

    // Memory-port arbitration: LOAD owns the port, otherwise a pending store drains.
    always_comb begin
        dm_we_s   = 1'b0;
        dm_addr_s = 32'd0;
        dm_din_s  = 32'd0;
        dm_ctrl_s = 3'd0;
        if (state_r == ST_LOAD) begin
            if (!ld_err_r) begin
                dm_addr_s = ld_addr_r;
                dm_ctrl_s = ld_ctrl_r;
            end else begin
                dm_addr_s = 32'd0;
            end
        end else if (sb_valid_r) begin
            dm_we_s   = 1'b1;
            dm_addr_s = sb_addr_r;
            dm_din_s  = sb_data_r;
            dm_ctrl_s = sb_ctrl_r;
        end else begin
            dm_we_s = 1'b0;
        end
    end

    assign req_ready = ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_rd    = rsp_rd_r;
    assign rsp_err   = rsp_err_r;
    assign DMWr      = dm_we_s;
    assign addr      = dm_addr_s;
    assign din       = dm_din_s;
    assign dm_ctrl   = dm_ctrl_s;
    assign busy      = sb_valid_r || (state_r != ST_IDLE);

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a byte-array data-memory model.
module tb_lsu;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        DMWr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [2:0]  dm_ctrl;
    logic [31:0] dout;
    logic        busy;

    int checks;
    int failures;

    logic [7:0] mem [0:1023];
    logic [9:0] a0;
    logic [9:0] a1;
    logic [9:0] a2;
    logic [9:0] a3;

    lsu #(.DM_BYTES(1024)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .DMWr(DMWr), .addr(addr), .din(din), .dm_ctrl(dm_ctrl), .dout(dout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a0 = addr[9:0];
    assign a1 = a0 + 10'd1;
    assign a2 = a0 + 10'd2;
    assign a3 = a0 + 10'd3;
    assign dout = {mem[a3], mem[a2], mem[a1], mem[a0]};

    // Little-endian memory model, written on the edge that ends a DMWr cycle.
    always @(posedge clk) begin
        if (DMWr) begin
            case (dm_ctrl)
                3'd0: begin
                    mem[a0] <= din[7:0];   mem[a1] <= din[15:8];
                    mem[a2] <= din[23:16]; mem[a3] <= din[31:24];
                end
                3'd1: begin
                    mem[a0] <= din[7:0];   mem[a1] <= din[15:8];
                end
                3'd3: mem[a0] <= din[7:0];
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [2:0] ctrl,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        req_valid = v;
        req_we    = we;
        req_ctrl  = ctrl;
        req_addr  = a;
        req_wdata = d;
        req_rd    = rd;
    endtask

    task automatic do_store(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] d);
        set_req(1'b1, 1'b1, ctrl, a, d, 5'd0);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
    endtask

    task automatic do_load(input logic [2:0] ctrl, input logic [31:0] a, input logic [4:0] rd);
        set_req(1'b1, 1'b0, ctrl, a, 32'd0, rd);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #12;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_dmwr", {31'd0, DMWr}, 32'd0);
        check("reset_addr", addr, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        tick();
        rstn = 1'b1;

        // Store then overlapping load: load held one cycle while the buffer drains.
        set_req(1'b1, 1'b1, 3'd0, 32'h10, 32'hDEADBEEF, 5'd0);
        #1 check("st10_ready", {31'd0, req_ready}, 32'd1);
        tick();
        set_req(1'b1, 1'b0, 3'd0, 32'h10, 32'd0, 5'd3);
        #1;
        check("ovl_ready_low", {31'd0, req_ready}, 32'd0);
        check("ovl_dmwr", {31'd0, DMWr}, 32'd1);
        check("ovl_addr", addr, 32'h10);
        check("ovl_din", din, 32'hDEADBEEF);
        check("ovl_busy", {31'd0, busy}, 32'd1);
        tick();
        check("ovl_ready_high", {31'd0, req_ready}, 32'd1);
        check("ovl_dmwr_low", {31'd0, DMWr}, 32'd0);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("ld10_port_addr", addr, 32'h10);
        check("ld10_port_we", {31'd0, DMWr}, 32'd0);
        check("ld10_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("ld10_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("ld10_rdata", rsp_rdata, 32'hDEADBEEF);
        check("ld10_rd", {27'd0, rsp_rd}, 32'd3);
        check("ld10_err", {31'd0, rsp_err}, 32'd0);
        tick();
        check("ld10_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

        // Extension of 0x000080F0 for each narrow load code.
        do_store(3'd0, 32'h20, 32'h000080F0);
        do_load(3'd3, 32'h20, 5'd1);
        check("ld_byte_sext", rsp_rdata, 32'hFFFFFFF0);
        do_load(3'd4, 32'h20, 5'd1);
        check("ld_byte_zext", rsp_rdata, 32'h000000F0);
        do_load(3'd1, 32'h20, 5'd1);
        check("ld_half_sext", rsp_rdata, 32'hFFFF80F0);
        do_load(3'd2, 32'h20, 5'd1);
        check("ld_half_zext", rsp_rdata, 32'h000080F0);

        // Back-to-back stores.
        set_req(1'b1, 1'b1, 3'd0, 32'h40, 32'h11111111, 5'd0);
        tick();
        set_req(1'b1, 1'b1, 3'd0, 32'h44, 32'h22222222, 5'd0);
        #1;
        check("b2b_ready", {31'd0, req_ready}, 32'd1);
        check("b2b_dmwr0", {31'd0, DMWr}, 32'd1);
        check("b2b_addr0", addr, 32'h40);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("b2b_dmwr1", {31'd0, DMWr}, 32'd1);
        check("b2b_addr1", addr, 32'h44);
        check("b2b_din1", din, 32'h22222222);
        tick();
        check("b2b_dmwr_done", {31'd0, DMWr}, 32'd0);
        check("b2b_idle", {31'd0, busy}, 32'd0);
        do_load(3'd0, 32'h40, 5'd2);
        check("b2b_readback40", rsp_rdata, 32'h11111111);
        do_load(3'd0, 32'h44, 5'd2);
        check("b2b_readback44", rsp_rdata, 32'h22222222);

        // Error cases.
        set_req(1'b1, 1'b0, 3'd0, 32'h42, 32'd0, 5'd7);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("ld_mis_port_addr", addr, 32'd0);
        check("ld_mis_busy", {31'd0, busy}, 32'd1);
        tick();
        check("ld_mis_valid", {31'd0, rsp_valid}, 32'd1);
        check("ld_mis_err", {31'd0, rsp_err}, 32'd1);
        check("ld_mis_rdata", rsp_rdata, 32'd0);
        check("ld_mis_rd", {27'd0, rsp_rd}, 32'd7);
        set_req(1'b1, 1'b1, 3'd3, 32'd1024, 32'hFF, 5'd9);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("st_oor_dmwr", {31'd0, DMWr}, 32'd0);
        check("st_oor_valid", {31'd0, rsp_valid}, 32'd1);
        check("st_oor_err", {31'd0, rsp_err}, 32'd1);
        check("st_oor_rd", {27'd0, rsp_rd}, 32'd9);
        check("st_oor_rdata", rsp_rdata, 32'd0);
        tick();
        check("st_oor_pulse", {31'd0, rsp_valid}, 32'd0);
        set_req(1'b1, 1'b1, 3'd2, 32'h50, 32'h1234, 5'd4);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("st_code_err", {31'd0, rsp_err}, 32'd1);
        check("st_code_dmwr", {31'd0, DMWr}, 32'd0);
        check("st_code_rd", {27'd0, rsp_rd}, 32'd4);
        tick();

        // Non-overlapping load accepted while the buffer drains.
        do_store(3'd0, 32'h90, 32'h12345678);
        set_req(1'b1, 1'b1, 3'd0, 32'h80, 32'hCAFEF00D, 5'd0);
        tick();
        set_req(1'b1, 1'b0, 3'd0, 32'h90, 32'd0, 5'd5);
        #1;
        check("nov_ready", {31'd0, req_ready}, 32'd1);
        check("nov_dmwr", {31'd0, DMWr}, 32'd1);
        check("nov_addr", addr, 32'h80);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("nov_load_we", {31'd0, DMWr}, 32'd0);
        check("nov_load_addr", addr, 32'h90);
        tick();
        check("nov_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("nov_rdata", rsp_rdata, 32'h12345678);
        check("nov_rd", {27'd0, rsp_rd}, 32'd5);
        do_load(3'd0, 32'h80, 5'd6);
        check("nov_readback80", rsp_rdata, 32'hCAFEF00D);

        // Reset with a buffered store pending.
        do_store(3'd0, 32'h100, 32'h01020304);
        set_req(1'b1, 1'b1, 3'd0, 32'h100, 32'hAAAA5555, 5'd0);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        #1;
        check("rst_pre_dmwr", {31'd0, DMWr}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("rst_dmwr_async", {31'd0, DMWr}, 32'd0);
        check("rst_addr_async", addr, 32'd0);
        check("rst_busy_async", {31'd0, busy}, 32'd0);
        tick();
        rstn = 1'b1;
        set_req(1'b1, 1'b0, 3'd0, 32'h100, 32'd0, 5'd8);
        #1 check("rst_ready_after", {31'd0, req_ready}, 32'd1);
        tick();
        set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
        tick();
        check("rst_mem_unchanged", rsp_rdata, 32'h01020304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
